// File: rtl/alu_xbar_tile.sv
// Compute tile: 4x4 input crossbar, registered two-input ALU, 2x1 output mux.
// Routing and opcode come from a 13-bit serial configuration chain.
module alu_xbar_tile #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            config_en,
  input  logic            config_in,
  output logic            config_out,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  input  logic [size-1:0] mem_in,
  output logic [size-1:0] mem_op0,
  output logic [size-1:0] mem_op1,
  output logic [size-1:0] alu_out,
  output logic [size-1:0] out0
);

  localparam int SHW = $clog2(size);

  logic [12:0]     cfg;
  logic [3:0]      op;
  logic            osel;
  logic [1:0]      s0, s1, s2, s3;
  logic [size-1:0] a, b, res, r;
  logic [SHW-1:0]  sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {cfg[11:0], config_in};
    end
  end

  assign op         = cfg[3:0];
  assign osel       = cfg[4];
  assign s0         = cfg[6:5];
  assign s1         = cfg[8:7];
  assign s2         = cfg[10:9];
  assign s3         = cfg[12:11];
  assign config_out = cfg[12];

  function automatic logic [size-1:0] pick(
    input logic [1:0]      s,
    input logic [size-1:0] i0,
    input logic [size-1:0] i1,
    input logic [size-1:0] fb,
    input logic [size-1:0] mi
  );
    logic [size-1:0] v;
    unique case (s)
      2'd0: v = i0;
      2'd1: v = i1;
      2'd2: v = fb;
      2'd3: v = mi;
    endcase
    return v;
  endfunction

  always_comb begin
    a       = pick(s0, in0, in1, r, mem_in);
    b       = pick(s1, in0, in1, r, mem_in);
    mem_op0 = pick(s2, in0, in1, r, mem_in);
    mem_op1 = pick(s3, in0, in1, r, mem_in);
  end

  assign sh = b[SHW-1:0];

  always_comb begin
    res = '0;
    unique case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a * b;
      4'd3:  res = a & b;
      4'd4:  res = a | b;
      4'd5:  res = a ^ b;
      4'd6:  res = a << sh;
      4'd7:  res = a >> sh;
      4'd8:  res = $unsigned($signed(a) >>> sh);
      4'd9:  res = {{(size-1){1'b0}}, a == b};
      4'd10: res = {{(size-1){1'b0}}, $signed(a) < $signed(b)};
      4'd11: res = {{(size-1){1'b0}}, a < b};
      4'd12: res = a;
      4'd13: res = b;
      4'd14: res = ($signed(a) < $signed(b)) ? a : b;
      4'd15: res = '0;
    endcase
  end

  // R breaks the alu_out -> crossbar -> ALU loop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
    end else begin
      r <= res;
    end
  end

  assign alu_out = r;
  assign out0    = osel ? mem_in : r;

endmodule

// File: tb/tb_alu_xbar_tile.sv
// Bench for alu_xbar_tile: directed table, corner sequences, random run
// checked every cycle against a behavioural model.
module tb_alu_xbar_tile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        config_en = 1'b0;
  logic        config_in = 1'b0;
  logic        config_out;
  logic [31:0] in0 = '0, in1 = '0, mem_in = '0;
  logic [31:0] mem_op0, mem_op1, alu_out, out0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] mc;
  logic [31:0] mr;
  logic        hist[$];

  alu_xbar_tile #(.size(32)) dut (
    .clk(clk), .reset(reset),
    .config_en(config_en), .config_in(config_in),
    .config_out(config_out),
    .in0(in0), .in1(in1), .mem_in(mem_in),
    .mem_op0(mem_op0), .mem_op1(mem_op1),
    .alu_out(alu_out), .out0(out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op,
      input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    int unsigned sh;
    logic [63:0] p, pw;
    ia = a;
    ib = b;
    sh = b % 32;
    pw = 64'd1 << sh;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  begin p = {32'd0, a} * pw; return p[31:0]; end
      7:  begin p = {32'd0, a} / pw; return p[31:0]; end
      8:  begin
            if (ia < 0) begin
              p = {32'd0, ~a} / pw;
              return ~p[31:0];
            end
            p = {32'd0, a} / pw;
            return p[31:0];
          end
      9:  return (a == b) ? 32'd1 : 32'd0;
      10: return (ia < ib) ? 32'd1 : 32'd0;
      11: return (a < b) ? 32'd1 : 32'd0;
      12: return a;
      13: return b;
      14: return (ia < ib) ? a : b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] xsel(input logic [1:0] s);
    case (s)
      2'd0: return in0;
      2'd1: return in1;
      2'd2: return mr;
      default: return mem_in;
    endcase
  endfunction

  function automatic logic exp_cout();
    if (hist.size() < 13) return 1'b0;
    return hist[hist.size() - 13];
  endfunction

  task automatic model_reset();
    mc = '0;
    mr = '0;
    hist.delete();
  endtask

  task automatic cycle(input logic en, input logic bit_in);
    logic [31:0] nxt;
    nxt = ref_alu(int'(mc[3:0]), xsel(mc[6:5]), xsel(mc[8:7]));
    config_en = en;
    config_in = bit_in;
    @(posedge clk);
    #1;
    mr = nxt;
    if (en) begin
      mc = {mc[11:0], bit_in};
      hist.push_back(bit_in);
    end
    chk("alu_out", alu_out, mr);
    chk("config_out", {31'd0, config_out}, {31'd0, exp_cout()});
    chk("out0", out0, mc[4] ? mem_in : mr);
    chk("mem_op0", mem_op0, xsel(mc[10:9]));
    chk("mem_op1", mem_op1, xsel(mc[12:11]));
  endtask

  task automatic shift_cfg(input logic [12:0] w);
    for (int i = 12; i >= 0; i--) cycle(1'b1, w[i]);
    config_en = 1'b0;
  endtask

  function automatic logic [12:0] mkcfg(input logic [1:0] s3,
      input logic [1:0] s2, input logic [1:0] s1, input logic [1:0] s0,
      input logic osel, input logic [3:0] op);
    return {s3, s2, s1, s0, osel, op};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"add",  4'd0,  32'd5,        32'd7,  32'd12});
    tbl.push_back('{"sub",  4'd1,  32'd0,        32'd1,  32'hFFFF_FFFF});
    tbl.push_back('{"mul",  4'd2,  32'h1_0000,   32'h1_0000, 32'd0});
    tbl.push_back('{"mul2", 4'd2,  32'd6,        32'd7,  32'd42});
    tbl.push_back('{"and",  4'd3,  32'hF0F0,     32'hFF00, 32'hF000});
    tbl.push_back('{"or",   4'd4,  32'hF0F0,     32'h0F00, 32'hFFF0});
    tbl.push_back('{"xor",  4'd5,  32'hFF00,     32'h0FF0, 32'hF0F0});
    tbl.push_back('{"ashr", 4'd8,  32'h8000_0000, 32'd4, 32'hF800_0000});
    tbl.push_back('{"lshr", 4'd7,  32'h8000_0000, 32'd4, 32'h0800_0000});
    tbl.push_back('{"shl",  4'd6,  32'h8000_0000, 32'd33, 32'd0});
    tbl.push_back('{"shl2", 4'd6,  32'd3,        32'd33, 32'd6});
    tbl.push_back('{"eq",   4'd9,  32'd5,        32'd5,  32'd1});
    tbl.push_back('{"slt",  4'd10, 32'hFFFF_FFFF, 32'd1, 32'd1});
    tbl.push_back('{"ult",  4'd11, 32'hFFFF_FFFF, 32'd1, 32'd0});
    tbl.push_back('{"min",  4'd14, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
    tbl.push_back('{"pasa", 4'd12, 32'd9,        32'd4,  32'd9});
    tbl.push_back('{"pasb", 4'd13, 32'd9,        32'd4,  32'd4});
    tbl.push_back('{"zero", 4'd15, 32'd9,        32'd4,  32'd0});

    model_reset();
    #2;
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_cout", {31'd0, config_out}, 32'd0);
    do_reset();

    // After reset: add in0+in0
    in0 = 32'd21;
    in1 = 32'd4;
    cycle(1'b0, 1'b0);
    chk("rst_add", alu_out, 32'd42);
    chk("rst_out0", out0, 32'd42);

    foreach (tbl[k]) begin
      in0 = tbl[k].a;
      in1 = tbl[k].b;
      shift_cfg(mkcfg(2'd0, 2'd0, 2'd1, 2'd0, 1'b0, tbl[k].op));
      cycle(1'b0, 1'b0);
      chk(tbl[k].nm, alu_out, tbl[k].exp);
      if (k == 0) chk("add_out0", out0, 32'd12);
    end

    // Accumulate from a zeroed result register
    do_reset();
    in0 = '0;
    in1 = '0;
    mem_in = '0;
    shift_cfg(mkcfg(2'd0, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0));
    chk("acc0", alu_out, 32'd0);
    in1 = 32'd3;
    cycle(1'b0, 1'b0);
    chk("acc3", alu_out, 32'd3);
    cycle(1'b0, 1'b0);
    chk("acc6", alu_out, 32'd6);
    cycle(1'b0, 1'b0);
    chk("acc9", alu_out, 32'd9);

    // Memory FU routing and output selector
    in0 = 32'd1;
    in1 = 32'd2;
    mem_in = 32'hABCD;
    shift_cfg(mkcfg(2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
    cycle(1'b0, 1'b0);
    chk("mem_out0", out0, 32'hABCD);
    chk("mem_op0v", mem_op0, 32'd1);
    chk("mem_op1v", mem_op1, 32'd2);

    // Asynchronous reset with chain tail high and nonzero result
    shift_cfg(mkcfg(2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
    cycle(1'b0, 1'b0);
    chk("pre_cout", {31'd0, config_out}, 32'd1);
    chk("pre_alu", alu_out, 32'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("async_alu", alu_out, 32'd0);
    chk("async_cout", {31'd0, config_out}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random: shifting while computing, all outputs checked each cycle
    for (int t = 0; t < 1500; t++) begin
      in0 = $urandom;
      in1 = ($urandom % 4 == 0) ? ($urandom % 40) : $urandom;
      mem_in = ($urandom % 4 == 0) ? in0 : $urandom;
      cycle($urandom % 3 != 0, 1'($urandom));
      if (t == 700) begin
        #2;
        reset = 1'b0;
        #1;
        chk("rnd_rst", alu_out, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_xbar_tile.md
Name: alu_xbar_tile

Overview:
- Compute tile: 4x4 fully-connected input crossbar feeding a registered two-input ALU, plus a 2x1 output selector.
- The crossbar also drives two operand ports for an external memory FU; that FU's result returns on mem_in.
- All routing and opcode settings live in a 13-bit serial configuration shift chain clocked by the datapath clock.

Parameters:
- size, 32, datapath width in bits (power of two, >= 8).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- config_en  input  1  when 1, configuration chain shifts one bit per clk.
- config_in  input  1  serial configuration data in.
- config_out  output  1  serial configuration data out (chain tail), for daisy-chaining.
- in0  input  size  tile input 0.
- in1  input  size  tile input 1.
- mem_in  input  size  result of external memory FU.
- mem_op0  output  size  crossbar output 2, operand 0 of external memory FU.
- mem_op1  output  size  crossbar output 3, operand 1 of external memory FU.
- alu_out  output  size  registered ALU result.
- out0  output  size  tile output.

Behaviour:
- Config chain C[12:0]:
  - reset low clears C to 0 asynchronously.
  - On a clk edge with config_en=1: C[0]<=config_in, C[i]<=C[i-1]. Hold otherwise.
  - config_out = C[12], combinational from the register.
  - Field map: op = C[3:0]; osel = C[4]; s0 = C[6:5]; s1 = C[8:7]; s2 = C[10:9]; s3 = C[12:11].
- Input crossbar, combinational: each xk is selected by sk as 0 = in0, 1 = in1, 2 = alu_out, 3 = mem_in.
  - x0 = ALU operand a, x1 = ALU operand b.
  - mem_op0 = x2, mem_op1 = x3.
- Output selector, combinational: out0 = alu_out when osel=0, mem_in when osel=1.
- ALU result register R:
  - reset low clears R to 0 asynchronously.
  - Otherwise R <= f(op, a, b) every clk edge, regardless of config_en.
  - alu_out = R; latency 1 cycle from operand change.
  - R breaks the alu_out -> crossbar -> ALU loop.
  - The external memory FU must itself be registered, so that mem_in -> mem_op* is not a combinational loop.
- ALU ops. All results are size bits, modular; sh = b[log2(size)-1:0].
  - 0 add a+b
  - 1 sub a-b
  - 2 mul, low size bits of a*b
  - 3 and
  - 4 or
  - 5 xor
  - 6 shl a<<sh
  - 7 lshr a>>sh, zero-fill
  - 8 ashr a>>>sh, sign-fill
  - 9 eq: 1 if a==b, else 0
  - 10 slt: 1 if signed a<b
  - 11 ult: 1 if unsigned a<b
  - 12 pass a
  - 13 pass b
  - 14 signed min(a,b)
  - 15 constant 0
- Config and data operation:
  - Shifting the config chain while computing is legal; R captures using the op and selects as they stand before that edge.
  - After reset: all selects = 0 (x0..x3 = in0), op = add, osel = 0. So after one clk, alu_out = in0+in0 and out0 = alu_out.
- Reset mid-operation: R and C go to 0 immediately on reset low, independent of clk. Normal operation resumes on the first edge after reset goes high.

Test Plan:
- Reset, then shift 13 bits with op=0, osel=0, s0=0, s1=1; in0=5, in1=7 -> alu_out=12 one cycle later; out0=12; config_out reproduces the bit config_in held 13 shifts earlier.
- op=1 with in0=0, in1=1 -> alu_out=0xFFFFFFFF. Then op=2 with in0=0x10000, in1=0x10000 -> alu_out=0.
- Accumulate: s0=2 (alu_out), s1=1, op=0, in1=3 from reset -> alu_out = 3, 6, 9 on successive cycles.
- op=8 with in0=0x80000000, in1=4 -> alu_out=0xF8000000. op=7, same inputs -> 0x08000000. op=6 with in1=33 (sh=1) -> 0.
- op=10 with in0=0xFFFFFFFF, in1=1 -> 1. op=11, same inputs -> 0. op=14 -> 0xFFFFFFFF.
- osel=1, s2=0, s3=1, mem_in=0xABCD, in0=1, in1=2 -> out0=0xABCD, mem_op0=1, mem_op1=2. Assert reset low mid-run -> alu_out=0 and config_out=0 without a clk edge.
